// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first. The result appears WIDTH+1 cycles after start.
// A start is ignored while busy. In DONE, a start is accepted directly, so operations can run back-to-back.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic bit_d;
  logic bit_br;

  // Full-subtractor cell applied to the current LSBs.
  assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        br_d  = bit_br;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bit_br;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // Status outputs come straight from the state register, so reset clears them asynchronously.
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin subtraction; sampled on rising clk edge.
REQ-005 Port: a  input  WIDTH  minuend; captured only on an accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend; captured only on an accepted start.
REQ-007 Port: busy  output  1  high while a subtraction is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking valid result.
REQ-009 Port: diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  final borrow out; 1 when a < b unsigned.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE, start=1 SHALL be accepted: latch a and b into shift registers, clear internal borrow flop, clear bit counter, go to RUN.
REQ-013 In RUN, each clock SHALL process one bit LSB-first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-014 Each RUN cycle SHALL shift d into the MSB of the internal result register and shift both operand registers right by one.
REQ-015 The bit counter SHALL count 0..WIDTH-1; after the RUN cycle processing bit WIDTH-1 the FSM SHALL go to DONE.
REQ-016 Latency: start sampled at edge k -> bits processed at edges k+1..k+WIDTH -> done high for the cycle after edge k+WIDTH.
REQ-017 diff and borrow SHALL update only at edge k+WIDTH (registered copy of final result and borrow) and hold until the next completion or reset.
REQ-018 busy SHALL be high exactly while in RUN; low in IDLE and DONE.
REQ-019 done SHALL be high exactly while in DONE (one cycle).
REQ-020 start while in RUN SHALL be ignored; operands and progress unaffected.
REQ-021 In DONE, start=1 SHALL be accepted as in IDLE (go directly to RUN, back-to-back operation); otherwise DONE -> IDLE.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH; no overflow flag; borrow reports a < b.
REQ-023 a and b changes outside an accepted start SHALL NOT affect the operation in progress.

Reset
REQ-024 rst_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, diff=0, borrow=0, internal counter, operand and borrow flops cleared.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow; diff/borrow read 0.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 a=0x05, b=0x03, start 1 cycle -> busy high 8 cycles, then done pulse, diff=0x02, borrow=0.
REQ-028 a=0x03, b=0x05 -> diff=0xFE, borrow=1; a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0x00, b=0x00 -> diff=0x00, borrow=0.
REQ-029 a=0xA5, b=0x5A, start; re-pulse start with a=0xFF, b=0x00 at RUN cycle 3 -> second start ignored, result diff=0x4B, borrow=0, exactly one done.
REQ-030 start held high through DONE with a=0x10, b=0x20 then a=0x20, b=0x10 -> back-to-back results diff=0xF0 borrow=1, then diff=0x10 borrow=0; busy low only during the DONE cycle.
REQ-031 Start a=0x80, b=0x01; assert rst_n=0 at RUN cycle 4 between edges -> busy, done, diff, borrow go 0 immediately, no done after release; new start a=0x80, b=0x01 -> diff=0x7F, borrow=0.
REQ-032 Exhaustive sweep of all 256x256 operand pairs against a - b reference model -> every diff and borrow match, every done exactly WIDTH+1 cycles after start.
